inv_key_schedule: RTL

- AES-128 inverse (reverse-order) key schedule for the decryption datapath.
- Takes a 128-bit key and streams round keys in reverse order, round NUM_ROUNDS down to 0, one per accepted handshake.
- Sits between key load and the inverse-cipher round logic. Lets decryption regenerate keys on the fly instead of storing all 11.

---
 rtl/aes_pkg.sv | 59 +++++
 rtl/inv_key_step.sv | 37 +++
 rtl/keyexpand.sv | 33 +++
 rtl/substituteOneColumn.sv | 43 ++++
 rtl/inv_key_schedule.sv | 121 ++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared AES key-schedule types, constants and helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    localparam int AES_ROUNDS = 10;

    typedef logic [15:0][7:0] aes_key_t;
    typedef logic [3:0][31:0] aes_words_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_EMIT = 2'd2
    } ks_state_e;

    // Round constant row-0 byte, index 0..9.
    function automatic logic [7:0] rcon_byte(input logic [3:0] idx);
        logic [7:0] rc;
        case (idx)
            4'd0:    rc = 8'h01;
            4'd1:    rc = 8'h02;
            4'd2:    rc = 8'h04;
            4'd3:    rc = 8'h08;
            4'd4:    rc = 8'h10;
            4'd5:    rc = 8'h20;
            4'd6:    rc = 8'h40;
            4'd7:    rc = 8'h80;
            4'd8:    rc = 8'h1b;
            4'd9:    rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    // Column c gathers bytes [15-c], [11-c], [7-c], [3-c]; row 0 lands in the MSB.
    function automatic aes_words_t key_to_words(input aes_key_t k);
        aes_words_t w;
        w[0] = {k[15], k[11], k[7], k[3]};
        w[1] = {k[14], k[10], k[6], k[2]};
        w[2] = {k[13], k[9],  k[5], k[1]};
        w[3] = {k[12], k[8],  k[4], k[0]};
        return w;
    endfunction

    function automatic aes_key_t words_to_key(input aes_words_t w);
        aes_key_t k;
        k = {w[0][31:24], w[1][31:24], w[2][31:24], w[3][31:24],
             w[0][23:16], w[1][23:16], w[2][23:16], w[3][23:16],
             w[0][15:8],  w[1][15:8],  w[2][15:8],  w[3][15:8],
             w[0][7:0],   w[1][7:0],   w[2][7:0],   w[3][7:0]};
        return k;
    endfunction

endpackage
`default_nettype wire

// File: rtl/inv_key_step.sv
`default_nettype none
// ============================================================================
// Module      : inv_key_step
// Description : Combinational previous-round-key computation (round i -> i-1).
// Revision    : 1.0 - initial release
// ============================================================================
module inv_key_step
    import aes_pkg::*;
(
    input  aes_key_t   i_key,
    input  logic [3:0] i_round,
    output aes_key_t   o_key
);

    aes_words_t  w_in;
    aes_words_t  w_out;
    logic [31:0] w_sub;
    logic [3:0]  w_rc_idx;

    assign w_in     = key_to_words(i_key);
    assign w_rc_idx = i_round - 4'd1;

    // Upper three words unwind first; w0 then reuses the recovered w3.
    assign w_out[3] = w_in[3] ^ w_in[2];
    assign w_out[2] = w_in[2] ^ w_in[1];
    assign w_out[1] = w_in[1] ^ w_in[0];

    substituteOneColumn u_sub (
        .i_col (({w_out[3][23:0], w_out[3][31:24]})),
        .o_col (w_sub)
    );

    assign w_out[0] = w_in[0] ^ w_sub ^ {rcon_byte(w_rc_idx), 24'h000000};
    assign o_key    = words_to_key(w_out);

endmodule
`default_nettype wire

// File: rtl/keyexpand.sv
`default_nettype none
// ============================================================================
// Module      : keyexpand
// Description : One forward AES-128 key-expansion round (round i -> i+1).
// Revision    : 1.0 - initial release
// ============================================================================
module keyexpand
    import aes_pkg::*;
(
    input  aes_key_t   i_key,
    input  logic [3:0] i_rc,
    output aes_key_t   o_key
);

    aes_words_t  w_in;
    aes_words_t  w_out;
    logic [31:0] w_sub;

    assign w_in = key_to_words(i_key);

    substituteOneColumn u_sub (
        .i_col (({w_in[3][23:0], w_in[3][31:24]})),
        .o_col (w_sub)
    );

    assign w_out[0] = w_in[0] ^ w_sub ^ {rcon_byte(i_rc), 24'h000000};
    assign w_out[1] = w_in[1] ^ w_out[0];
    assign w_out[2] = w_in[2] ^ w_out[1];
    assign w_out[3] = w_in[3] ^ w_out[2];
    assign o_key    = words_to_key(w_out);

endmodule
`default_nettype wire

// File: rtl/substituteOneColumn.sv
`default_nettype none
// ============================================================================
// Module      : substituteOneColumn
// Description : AES S-box applied to each byte of a 32-bit column.
// Revision    : 1.0 - initial release
// ============================================================================
module substituteOneColumn (
    input  logic [31:0] i_col,
    output logic [31:0] o_col
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ ({8{aa[7]}} & 8'h1b);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0), followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = gf_mul(x, x);
        inv = sq;
        for (int k = 0; k < 6; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_byte
        assign o_col[8*g +: 8] = sbox(i_col[8*g +: 8]);
    end

endmodule
`default_nettype wire

// File: rtl/inv_key_schedule.sv
`default_nettype none
// ============================================================================
// Module      : inv_key_schedule
// Description : Streams AES-128 round keys in reverse order, round 10 down to 0.
//               INV_KEY_FWD_PRECOMPUTE_EN: key_in is the cipher key and is
//               forward-expanded in-block before the reverse stream starts.
// Revision    : 1.0 - initial release
// ============================================================================
module inv_key_schedule
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = AES_ROUNDS
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     load_valid,
    output logic     load_ready,
    input  aes_key_t key_in,
    output logic     key_valid,
    input  logic     key_ready,
    output aes_key_t key_out,
    output logic [3:0] key_round,
    output logic     done
);

    localparam logic [3:0] c_LAST_ROUND = 4'(NUM_ROUNDS);

    ks_state_e  r_state;
    aes_key_t   r_key;
    logic [3:0] r_round;
    logic       r_valid;
    logic       r_load_ready;
    logic       r_done;
    aes_key_t   w_prev_key;

    inv_key_step u_step (
        .i_key   (r_key),
        .i_round (r_round),
        .o_key   (w_prev_key)
    );

`ifdef INV_KEY_FWD_PRECOMPUTE_EN
    logic [3:0] r_rc;
    aes_key_t   w_fwd_key;

    keyexpand u_fwd (
        .i_key (r_key),
        .i_rc  (r_rc),
        .o_key (w_fwd_key)
    );
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_key        <= '0;
            r_round      <= 4'd0;
            r_valid      <= 1'b0;
            r_load_ready <= 1'b1;
            r_done       <= 1'b0;
`ifdef INV_KEY_FWD_PRECOMPUTE_EN
            r_rc         <= 4'd0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (load_valid) begin
                        r_key        <= key_in;
                        r_load_ready <= 1'b0;
`ifdef INV_KEY_FWD_PRECOMPUTE_EN
                        r_state      <= ST_FWD;
                        r_rc         <= 4'd0;
`else
                        r_state      <= ST_EMIT;
                        r_round      <= c_LAST_ROUND;
                        r_valid      <= 1'b1;
`endif
                    end
                end
`ifdef INV_KEY_FWD_PRECOMPUTE_EN
                ST_FWD: begin
                    r_key <= w_fwd_key;
                    r_rc  <= r_rc + 4'd1;
                    if (r_rc == c_LAST_ROUND - 4'd1) begin
                        r_state <= ST_EMIT;
                        r_round <= c_LAST_ROUND;
                        r_valid <= 1'b1;
                    end
                end
`endif
                ST_EMIT: begin
                    if (key_ready) begin
                        if (r_round == 4'd0) begin
                            r_state      <= ST_IDLE;
                            r_valid      <= 1'b0;
                            r_done       <= 1'b1;
                            r_load_ready <= 1'b1;
                        end else begin
                            r_key   <= w_prev_key;
                            r_round <= r_round - 4'd1;
                        end
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_valid      <= 1'b0;
                    r_load_ready <= 1'b1;
                end
            endcase
        end
    end

    assign load_ready = r_load_ready;
    assign key_valid  = r_valid;
    assign key_out    = r_key;
    assign key_round  = r_round;
    assign done       = r_done;

endmodule
`default_nettype wire
